// File: rtl/clk_set_controller.sv
// Button front-end and RUN/SET sequencer for the 24-hour clock datapath.
// Produces digit-increment strobes, the 1 Hz run tick and the edit blink.
module clk_set_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_q;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      press   <= level & ~level_q;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module clk_set_controller #(
  parameter int CLK_DIV         = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES  = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       set_time,
  output logic       hour10,
  output logic       hour1,
  output logic       min10,
  output logic       min1,
  output logic       sec10,
  output logic       sec1,
  output logic       tick,
  output logic [2:0] field_sel,
  output logic       blink
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_H10 = 3'd1,
    SET_H1  = 3'd2,
    SET_M10 = 3'd3,
    SET_M1  = 3'd4,
    SET_S10 = 3'd5,
    SET_S1  = 3'd6
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          mode_ev;
  logic          inc_ev;
  logic          timeout;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] icnt;

  clk_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (mode_btn),
    .press (mode_ev)
  );

  clk_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .press (inc_ev)
  );

  assign field_sel = state;

  // Any press in the timeout cycle defers the return to RUN.
  always_comb begin
    timeout = (state != RUN) && (icnt == TW'(TIMEOUT_CYCLES - 1));
    nxt     = state;
    if (mode_ev) begin
      unique case (state)
        RUN:     nxt = SET_H10;
        SET_H10: nxt = SET_H1;
        SET_H1:  nxt = SET_M10;
        SET_M10: nxt = SET_M1;
        SET_M1:  nxt = SET_S10;
        SET_S10: nxt = SET_S1;
        default: nxt = RUN;
      endcase
    end else if (timeout && !inc_ev) begin
      nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      set_time <= 1'b0;
      {hour10, hour1, min10, min1, sec10, sec1} <= 6'b0;
      tick     <= 1'b0;
      pcnt     <= '0;
      blink    <= 1'b1;
      bcnt     <= '0;
      icnt     <= '0;
    end else begin
      state    <= nxt;
      set_time <= (nxt != RUN);

      {hour10, hour1, min10, min1, sec10, sec1} <= 6'b0;
      if (inc_ev && !mode_ev) begin
        unique case (state)
          SET_H10: hour10 <= 1'b1;
          SET_H1:  hour1  <= 1'b1;
          SET_M10: min10  <= 1'b1;
          SET_M1:  min1   <= 1'b1;
          SET_S10: sec10  <= 1'b1;
          SET_S1:  sec1   <= 1'b1;
          default: ;
        endcase
      end

      if (state == RUN && nxt == RUN) begin
        if (pcnt == PW'(CLK_DIV - 1)) begin
          pcnt <= '0;
          tick <= 1'b1;
        end else begin
          pcnt <= pcnt + PW'(1);
          tick <= 1'b0;
        end
      end else begin
        pcnt <= '0;
        tick <= 1'b0;
      end

      if (nxt == RUN || state == RUN || mode_ev) begin
        blink <= 1'b1;
        bcnt  <= '0;
      end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
        blink <= ~blink;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + BW'(1);
      end

      if (nxt == RUN || state == RUN || mode_ev || inc_ev) begin
        icnt <= '0;
      end else begin
        icnt <= icnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_clk_set_controller.sv
// Directed bench for clk_set_controller with a strobe scoreboard.
// Small parameters keep debounce, tick, blink and timeout visible.
module tb_clk_set_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       set_time;
  logic       hour10, hour1, min10, min1, sec10, sec1;
  logic       tick;
  logic [2:0] field_sel;
  logic       blink;
  logic [5:0] strobes;

  int checks = 0;
  int failures = 0;
  int ticks_in_set = 0;
  logic [5:0] exp_q[$];

  assign strobes = {hour10, hour1, min10, min1, sec10, sec1};

  always #5 clk = ~clk;

  clk_set_controller #(
    .CLK_DIV         (10),
    .DEBOUNCE_CYCLES (4),
    .BLINK_CYCLES    (3),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .set_time  (set_time),
    .hour10    (hour10),
    .hour1     (hour1),
    .min10     (min10),
    .min1      (min1),
    .sec10     (sec10),
    .sec1      (sec1),
    .tick      (tick),
    .field_sel (field_sel),
    .blink     (blink)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (tick && set_time) ticks_in_set++;
      if (strobes != 6'b0) begin
        if (exp_q.size() == 0)
          chk("unexpected_strobe", 32'(strobes), 32'd0);
        else
          chk("strobe", 32'({set_time, strobes}),
              32'({1'b1, exp_q.pop_front()}));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    cyc(12);
    mode_btn = 1'b0;
    cyc(10);
  endtask

  task automatic press_inc(input logic [5:0] exp);
    if (exp != 6'b0) exp_q.push_back(exp);
    inc_btn = 1'b1;
    cyc(12);
    inc_btn = 1'b0;
    cyc(10);
  endtask

  task automatic sb_empty(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [5:0] v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_set_time", 32'(set_time), 32'd0);
    chk("rst_field_sel", 32'(field_sel), 32'd0);
    chk("rst_blink", 32'(blink), 32'd1);
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("tick_after_reset", 32'(tick), 32'((i % 10) == 0));
    end

    mode_btn = 1'b1;
    cyc(7);
    chk("mode_latency_pre", 32'(field_sel), 32'd0);
    cyc(1);
    chk("mode_latency", 32'(field_sel), 32'd1);
    chk("set_time_h10", 32'(set_time), 32'd1);
    chk("blink_entry", 32'(blink), 32'd1);
    cyc(2);
    chk("blink_hold", 32'(blink), 32'd1);
    cyc(1);
    chk("blink_off", 32'(blink), 32'd0);
    cyc(3);
    chk("blink_on", 32'(blink), 32'd1);
    mode_btn = 1'b0;
    cyc(10);
    for (int i = 2; i <= 6; i++) begin
      press_mode();
      chk("mode_cycle_sel", 32'(field_sel), 32'(i));
      chk("mode_cycle_set", 32'(set_time), 32'd1);
    end
    mode_btn = 1'b1;
    n = 0;
    while (field_sel != 3'd0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    mode_btn = 1'b0;
    chk("return_run", 32'(field_sel), 32'd0);
    chk("return_set_time", 32'(set_time), 32'd0);
    n = 0;
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_after_set", 32'(n), 32'd10);
    chk("no_tick_in_set", 32'(ticks_in_set), 32'd0);
    cyc(10);

    repeat (4) press_mode();
    chk("enter_m1", 32'(field_sel), 32'd4);
    inc_btn = 1'b1;
    cyc(3);
    inc_btn = 1'b0;
    cyc(10);
    sb_empty("glitch_queue");
    exp_q.push_back(6'b000100);
    inc_btn = 1'b1;
    cyc(7);
    chk("inc_latency_pre", 32'(strobes), 32'd0);
    cyc(1);
    chk("inc_latency", 32'(strobes), 32'h04);
    cyc(1);
    chk("inc_one_cycle", 32'(strobes), 32'd0);
    cyc(100);
    inc_btn = 1'b0;
    cyc(10);
    sb_empty("hold_single_strobe");
    chk("hold_timeout_run", 32'(field_sel), 32'd0);

    press_inc(6'b0);
    sb_empty("inc_in_run");
    for (int i = 1; i <= 6; i++) begin
      press_mode();
      chk("route_sel", 32'(field_sel), 32'(i));
      v = 6'b100000 >> (i - 1);
      press_inc(v);
      sb_empty("route_strobe");
    end
    press_mode();
    chk("route_back_run", 32'(field_sel), 32'd0);

    press_mode();
    mode_btn = 1'b1;
    inc_btn = 1'b1;
    cyc(12);
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    cyc(10);
    chk("simul_mode_wins", 32'(field_sel), 32'd2);
    sb_empty("simul_no_strobe");

    mode_btn = 1'b1;
    cyc(10);
    mode_btn = 1'b0;
    cyc(40);
    exp_q.push_back(6'b001000);
    inc_btn = 1'b1;
    cyc(8);
    chk("timeout_cycle_strobe", 32'(strobes), 32'h08);
    inc_btn = 1'b0;
    cyc(49);
    chk("timeout_deferred", 32'(field_sel), 32'd3);
    cyc(1);
    chk("timeout_after_inc", 32'(field_sel), 32'd0);
    sb_empty("timeout_queue");

    repeat (4) press_mode();
    mode_btn = 1'b1;
    cyc(10);
    mode_btn = 1'b0;
    cyc(47);
    chk("idle_before", 32'(field_sel), 32'd5);
    chk("idle_before_set", 32'(set_time), 32'd1);
    cyc(1);
    chk("idle_timeout_sel", 32'(field_sel), 32'd0);
    chk("idle_timeout_set", 32'(set_time), 32'd0);
    chk("idle_timeout_blink", 32'(blink), 32'd1);

    repeat (3) press_mode();
    chk("enter_m10", 32'(field_sel), 32'd3);
    inc_btn = 1'b1;
    cyc(5);
    reset = 1'b0;
    inc_btn = 1'b0;
    cyc(2);
    reset = 1'b1;
    chk("mid_reset_sel", 32'(field_sel), 32'd0);
    chk("mid_reset_set", 32'(set_time), 32'd0);
    chk("mid_reset_blink", 32'(blink), 32'd1);
    cyc(20);
    sb_empty("mid_reset_no_strobe");
    chk("mid_reset_strobes", 32'(strobes), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
